mc_addr_gen: RTL and testbench
==============================

MC_ADDR_GEN -- requirements
Module: mc_addr_gen

Interface
REQ-001 Parameter ADDR_W, default 31, address width in bits (legal range 2..32).
REQ-002 Parameter CNT_W, default 32, transaction-count width.
REQ-003 Parameter LFSR_SEED, default 32'h0000_0001, random-mode seed; a value of 0 SHALL be replaced by 1.
REQ-004 Port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-005 Port rst_i, input, 1, asynchronous active-low reset.
REQ-006 Port start_i, input, 1, one-cycle run request.
REQ-007 Port addr_mode_i, input, 3, mode code: 000 FIX, 001 RND, 010 RUN_0, 011 RUN_1, 100 INC, 101 DEC (new); 110 and 111 are reserved.
REQ-008 Ports base_addr_i and high_addr_i, input, ADDR_W each, lower and upper bounds (inclusive); base_addr_i is also the FIX address.
REQ-009 Port stride_i, input, 8, INC/DEC step.
REQ-010 Port trans_cnt_i, input, CNT_W, number of addresses to emit.
REQ-011 Port addr_o, output, ADDR_W, generated address.
REQ-012 Port addr_valid_o, output, 1, addr_o is valid.
REQ-013 Port addr_ready_i, input, 1, the consumer accepts addr_o.
REQ-014 Port busy_o, output, 1, a run is in progress.
REQ-015 Port done_o, output, 1, one-cycle end-of-run pulse.

Function
REQ-016 The FSM SHALL have two states: IDLE and RUN.
REQ-017 In IDLE, start_i=1 SHALL latch mode, bounds, stride and count, reseed the LFSR, and load the first address; on the next cycle the FSM is in RUN with busy_o=1 and addr_valid_o=1.
REQ-018 start_i asserted while in RUN SHALL be ignored.
REQ-019 A handshake occurs when addr_valid_o=1 and addr_ready_i=1; only a handshake advances the address and decrements the remaining count.
REQ-020 While addr_valid_o=1 and addr_ready_i=0, addr_o SHALL stay constant.
REQ-021 On the handshake that consumes the last address, the FSM SHALL return to IDLE: next cycle addr_valid_o=0, busy_o=0 and done_o=1 for exactly one cycle.
REQ-022 With trans_cnt_i=0, the FSM SHALL stay in IDLE, emit no address, and pulse done_o on the cycle after start_i.
REQ-023 FIX SHALL emit base_addr_i on every handshake.
REQ-024 RND SHALL use a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1, starting from LFSR_SEED and advancing once per handshake; addr_o = lfsr[ADDR_W-1:0].
REQ-025 RUN_1 SHALL emit a walking one 1<<k, with k starting at 0, incrementing per handshake and wrapping from ADDR_W-1 back to 0.
REQ-026 RUN_0 SHALL emit the bitwise inverse of the RUN_1 pattern, using the same k sequence.
REQ-027 INC SHALL start at base and compute next = cur + stride (stride 0 treated as 1); if the sum exceeds high or carries out of ADDR_W, next SHALL be base.
REQ-028 DEC SHALL start at high and compute next = cur - stride (stride 0 treated as 1); if the result is below base or borrows, next SHALL be high.
REQ-029 For INC or DEC with base > high, the block SHALL emit base on every handshake.
REQ-030 Reserved mode codes SHALL behave as FIX.
REQ-031 Address arithmetic SHALL be done in ADDR_W+1 bits so that carry and borrow are detected.

Reset
REQ-032 While rst_i=0, the FSM SHALL be IDLE and addr_o, addr_valid_o, busy_o, done_o and the remaining count SHALL be 0; the LFSR SHALL hold LFSR_SEED and k SHALL be 0.
REQ-033 Reset asserted mid-run SHALL abort the run immediately, with no done_o pulse; after reset deasserts, the block SHALL wait for a new start_i.

Verification
REQ-034 INC, base=0x10, high=0x1C, stride=4, count=5, ready=1 -> addr_o 0x10,0x14,0x18,0x1C,0x10; done_o pulses on the cycle after the 5th handshake.
REQ-035 DEC, base=0x08, high=0x20, stride=0x10, count=4 -> addr_o 0x20,0x10,0x20,0x10.
REQ-036 RUN_0 with ADDR_W=4, count=6 -> addr_o 0xE,0xD,0xB,0x7,0xE,0xD.
REQ-037 RND, count=3, ready toggling 1/0 each cycle -> three distinct addresses, each held while ready=0; rerunning with identical settings -> the same three addresses.
REQ-038 FIX, count=0 -> addr_valid_o stays 0 and done_o pulses once on the cycle after start_i; start_i pulsed mid-run in INC -> no effect on the sequence.
REQ-039 Reset asserted after 2 of 8 handshakes -> all outputs 0, no done_o pulse; a new start_i restarts the sequence from its first address.

Source files
------------

// File: rtl/mc_addr_gen_if.sv
// Request/configuration and address handshake bundle for mc_addr_gen.
// master = address consumer / controller, slave = the generator.
interface mc_addr_gen_if #(
  parameter int ADDR_W = 31,
  parameter int CNT_W  = 32
);
  logic              start_i;
  logic [2:0]        addr_mode_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W-1:0] high_addr_i;
  logic [7:0]        stride_i;
  logic [CNT_W-1:0]  trans_cnt_i;
  logic [ADDR_W-1:0] addr_o;
  logic              addr_valid_o;
  logic              addr_ready_i;
  logic              busy_o;
  logic              done_o;

  modport master (
    output start_i, addr_mode_i, base_addr_i, high_addr_i, stride_i, trans_cnt_i,
    output addr_ready_i,
    input  addr_o, addr_valid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, addr_mode_i, base_addr_i, high_addr_i, stride_i, trans_cnt_i,
    input  addr_ready_i,
    output addr_o, addr_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/mc_addr_gen.sv
// Memory-test address generator: fixed, LFSR-random, walking 0/1 and
// bounded increment/decrement sequences behind a valid/ready handshake.
module mc_addr_gen #(
  parameter int          ADDR_W    = 31,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mc_addr_gen_if.slave bus
);

  localparam int          K_W       = (ADDR_W > 2) ? $clog2(ADDR_W) : 1;
  // Wide enough for both the ADDR_W carry bit and the full 8-bit stride.
  localparam int          SUM_W     = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
  localparam logic [31:0] SEED      = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [2:0] M_FIX  = 3'd0;
  localparam logic [2:0] M_RND  = 3'd1;
  localparam logic [2:0] M_RUN0 = 3'd2;
  localparam logic [2:0] M_RUN1 = 3'd3;
  localparam logic [2:0] M_INC  = 3'd4;
  localparam logic [2:0] M_DEC  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_nxt;
  logic              load, adv, done_nxt, done_q;
  logic [2:0]        mode_in, mode_q;
  logic [ADDR_W-1:0] base_q, high_q, addr_q, addr_first, addr_nxt;
  logic [7:0]        stride_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       lfsr_q, lfsr_nxt;
  logic [K_W-1:0]    k_q, k_nxt;

  function automatic logic [ADDR_W-1:0] walk(input logic [K_W-1:0] k);
    logic [ADDR_W-1:0] w;
    w    = '0;
    w[k] = 1'b1;
    return w;
  endfunction

  function automatic logic [ADDR_W-1:0] step_inc(input logic [ADDR_W-1:0] cur, base, high,
                                                 input logic [7:0] stride);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cur) + SUM_W'(stride);
    if (base > high || sum > SUM_W'(high)) return base;
    return sum[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] step_dec(input logic [ADDR_W-1:0] cur, base, high,
                                                 input logic [7:0] stride);
    logic [SUM_W-1:0] diff;
    diff = SUM_W'(cur) - SUM_W'(stride);
    if (base > high) return base;
    if (diff[SUM_W-1] || diff < SUM_W'(base)) return high;
    return diff[ADDR_W-1:0];
  endfunction

  assign mode_in  = (bus.addr_mode_i > M_DEC) ? M_FIX : bus.addr_mode_i;
  assign lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
  assign k_nxt    = (k_q == K_W'(ADDR_W - 1)) ? '0 : k_q + K_W'(1);

  always_comb begin
    case (mode_in)
      M_RND:   addr_first = SEED[ADDR_W-1:0];
      M_RUN1:  addr_first = walk('0);
      M_RUN0:  addr_first = ~walk('0);
      M_DEC:   addr_first = (bus.base_addr_i > bus.high_addr_i) ? bus.base_addr_i
                                                                 : bus.high_addr_i;
      default: addr_first = bus.base_addr_i;
    endcase
  end

  always_comb begin
    case (mode_q)
      M_RND:   addr_nxt = lfsr_nxt[ADDR_W-1:0];
      M_RUN1:  addr_nxt = walk(k_nxt);
      M_RUN0:  addr_nxt = ~walk(k_nxt);
      M_INC:   addr_nxt = step_inc(addr_q, base_q, high_q, stride_q);
      M_DEC:   addr_nxt = step_dec(addr_q, base_q, high_q, stride_q);
      default: addr_nxt = base_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt        = state_q;
    load             = 1'b0;
    adv              = 1'b0;
    done_nxt         = 1'b0;
    bus.addr_valid_o = 1'b0;
    bus.busy_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.trans_cnt_i == '0) begin
            done_nxt = 1'b1;
          end else begin
            load      = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        bus.addr_valid_o = 1'b1;
        bus.busy_o       = 1'b1;
        if (bus.addr_ready_i) begin
          adv = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mode_q   <= M_FIX;
      base_q   <= '0;
      high_q   <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
      lfsr_q   <= SEED;
      k_q      <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_nxt;
      if (load) begin
        mode_q   <= mode_in;
        base_q   <= bus.base_addr_i;
        high_q   <= bus.high_addr_i;
        stride_q <= (bus.stride_i == 8'd0) ? 8'd1 : bus.stride_i;
        cnt_q    <= bus.trans_cnt_i;
        lfsr_q   <= SEED;
        k_q      <= '0;
        addr_q   <= addr_first;
      end else if (adv) begin
        cnt_q  <= cnt_q - CNT_W'(1);
        lfsr_q <= lfsr_nxt;
        k_q    <= k_nxt;
        addr_q <= addr_nxt;
      end
    end
  end

  assign bus.addr_o = addr_q;
  assign bus.done_o = done_q;

endmodule

// File: tb/tb_mc_addr_gen.sv
// Directed scoreboard bench for mc_addr_gen (31-bit main instance plus a
// 4-bit instance for the narrow walking-zero sequence).
module tb_mc_addr_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en4   = 1'b0;

  always #5 clk = ~clk;

  mc_addr_gen_if #(.ADDR_W(31), .CNT_W(32)) bus ();
  mc_addr_gen_if #(.ADDR_W(4),  .CNT_W(32)) bus4 ();

  mc_addr_gen #(.ADDR_W(31), .CNT_W(32), .LFSR_SEED(32'h0000_0001)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  mc_addr_gen #(.ADDR_W(4), .CNT_W(32), .LFSR_SEED(32'h0000_0001)) dut4 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus4)
  );

  assign bus4.start_i      = bus.start_i & en4;
  assign bus4.addr_mode_i  = bus.addr_mode_i;
  assign bus4.base_addr_i  = bus.base_addr_i[3:0];
  assign bus4.high_addr_i  = bus.high_addr_i[3:0];
  assign bus4.stride_i     = bus.stride_i;
  assign bus4.trans_cnt_i  = bus.trans_cnt_i;
  assign bus4.addr_ready_i = bus.addr_ready_i;

  logic [30:0] exp_q[$];
  logic [3:0]  exp4_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          hs_cnt   = 0;
  bit          prev_last, prev_done, stall, stall4;
  logic [30:0] held;
  logic [3:0]  held4;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    bit          last;
    logic [30:0] e;
    logic [3:0]  e4;
    last = 1'b0;
    if (!rst_n) begin
      stall     = 1'b0;
      stall4    = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bus.done_o) begin
        done_cnt++;
        chk("done_after_last", {63'd0, prev_last}, 64'd1);
        chk("done_one_cycle", {63'd0, prev_done}, 64'd0);
        chk("done_valid_low", {63'd0, bus.addr_valid_o}, 64'd0);
        chk("done_busy_low", {63'd0, bus.busy_o}, 64'd0);
      end
      prev_done = bus.done_o;
      if (bus.addr_valid_o) begin
        if (stall) chk("hold_addr", 64'(bus.addr_o), 64'(held));
        stall = !bus.addr_ready_i;
        held  = bus.addr_o;
        if (bus.addr_ready_i) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            chk("spurious_valid", {63'd0, bus.addr_valid_o}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("addr", 64'(bus.addr_o), 64'(e));
            last = (exp_q.size() == 0);
          end
        end
      end else begin
        stall = 1'b0;
      end
      if (bus.start_i && !bus.busy_o && bus.trans_cnt_i == 32'd0) last = 1'b1;
      if (bus4.addr_valid_o) begin
        if (stall4) chk("hold_addr4", 64'(bus4.addr_o), 64'(held4));
        stall4 = !bus4.addr_ready_i;
        held4  = bus4.addr_o;
        if (bus4.addr_ready_i) begin
          if (exp4_q.size() == 0) begin
            chk("spurious_valid4", {63'd0, bus4.addr_valid_o}, 64'd0);
          end else begin
            e4 = exp4_q.pop_front();
            chk("addr4", 64'(bus4.addr_o), 64'(e4));
          end
        end
      end else begin
        stall4 = 1'b0;
      end
    end
    prev_last = last;
  end

  task automatic run(input logic [2:0] mode, input logic [30:0] base, input logic [30:0] high,
                     input logic [7:0] stride, input logic [31:0] cnt, input bit tog,
                     input bit mid_start);
    done_cnt = 0;
    @(posedge clk); #1;
    bus.addr_mode_i  = mode;
    bus.base_addr_i  = base;
    bus.high_addr_i  = high;
    bus.stride_i     = stride;
    bus.trans_cnt_i  = cnt;
    bus.addr_ready_i = 1'b1;
    bus.start_i      = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    if (cnt != 32'd0) begin
      chk("busy_after_start", {63'd0, bus.busy_o}, 64'd1);
      chk("valid_after_start", {63'd0, bus.addr_valid_o}, 64'd1);
    end
    for (int c = 0; c < 400; c++) begin
      if (done_cnt != 0) break;
      @(posedge clk); #1;
      if (tog) bus.addr_ready_i = ~bus.addr_ready_i;
      if (mid_start && c == 1) begin
        bus.start_i     = 1'b1;
        bus.base_addr_i = 31'h0;
        bus.addr_mode_i = 3'b000;
      end else begin
        bus.start_i = 1'b0;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("seq_drained", 64'(exp_q.size()), 64'd0);
    chk("seq4_drained", 64'(exp4_q.size()), 64'd0);
  endtask

  initial begin
    bus.start_i      = 1'b0;
    bus.addr_mode_i  = 3'b000;
    bus.base_addr_i  = '0;
    bus.high_addr_i  = '0;
    bus.stride_i     = 8'd0;
    bus.trans_cnt_i  = 32'd0;
    bus.addr_ready_i = 1'b1;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", 64'(bus.addr_o), 64'd0);
    chk("rst_valid", {63'd0, bus.addr_valid_o}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy_o}, 64'd0);
    chk("rst_done", {63'd0, bus.done_o}, 64'd0);
    rst_n = 1'b1;

    // INC wrap to base once the sum passes high
    exp_q = {31'h10, 31'h14, 31'h18, 31'h1C, 31'h10};
    run(3'b100, 31'h10, 31'h1C, 8'd4, 32'd5, 1'b0, 1'b0);

    // DEC falls below base and restarts at high
    exp_q = {31'h20, 31'h10, 31'h20, 31'h10};
    run(3'b101, 31'h08, 31'h20, 8'h10, 32'd4, 1'b0, 1'b0);

    // Walking zero on both widths, k wraps at ADDR_W-1 on the narrow one
    en4    = 1'b1;
    exp4_q = {4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD};
    exp_q  = {31'h7FFF_FFFE, 31'h7FFF_FFFD, 31'h7FFF_FFFB, 31'h7FFF_FFF7,
              31'h7FFF_FFEF, 31'h7FFF_FFDF};
    run(3'b010, 31'h0, 31'h0, 8'd0, 32'd6, 1'b0, 1'b0);
    en4 = 1'b0;

    // Random mode with ready toggling, then an identical rerun
    exp_q = {31'h0000_0001, 31'h0020_0003, 31'h4030_0002};
    run(3'b001, 31'h0, 31'h0, 8'd0, 32'd3, 1'b1, 1'b0);
    exp_q = {31'h0000_0001, 31'h0020_0003, 31'h4030_0002};
    run(3'b001, 31'h0, 31'h0, 8'd0, 32'd3, 1'b1, 1'b0);

    // Zero-length FIX run, then start pulsed mid-run in INC
    run(3'b000, 31'h55, 31'h0, 8'd0, 32'd0, 1'b0, 1'b0);
    exp_q = {31'h10, 31'h14, 31'h18, 31'h1C, 31'h10};
    run(3'b100, 31'h10, 31'h1C, 8'd4, 32'd5, 1'b0, 1'b1);

    // Carry out of ADDR_W, stride 0, base above high, reserved mode
    exp_q = {31'h7FFF_FFFC, 31'h7FFF_FFFC, 31'h7FFF_FFFC};
    run(3'b100, 31'h7FFF_FFFC, 31'h7FFF_FFFF, 8'd4, 32'd3, 1'b0, 1'b0);
    exp_q = {31'h0, 31'h1, 31'h2, 31'h0};
    run(3'b100, 31'h0, 31'h2, 8'd0, 32'd4, 1'b0, 1'b0);
    exp_q = {31'h40, 31'h40};
    run(3'b101, 31'h40, 31'h30, 8'd1, 32'd2, 1'b0, 1'b0);
    exp_q = {31'h55, 31'h55};
    run(3'b111, 31'h55, 31'h60, 8'd1, 32'd2, 1'b0, 1'b0);

    // Reset after two of eight handshakes
    exp_q    = {31'h20, 31'h21, 31'h22, 31'h23, 31'h24, 31'h25, 31'h26, 31'h27};
    done_cnt = 0;
    hs_cnt   = 0;
    @(posedge clk); #1;
    bus.addr_mode_i  = 3'b100;
    bus.base_addr_i  = 31'h20;
    bus.high_addr_i  = 31'hFF;
    bus.stride_i     = 8'd1;
    bus.trans_cnt_i  = 32'd8;
    bus.addr_ready_i = 1'b1;
    bus.start_i      = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (hs_cnt >= 2) break;
      @(posedge clk); #1;
    end
    chk("hs_before_reset", 64'(hs_cnt), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_addr", 64'(bus.addr_o), 64'd0);
    chk("abort_valid", {63'd0, bus.addr_valid_o}, 64'd0);
    chk("abort_busy", {63'd0, bus.busy_o}, 64'd0);
    chk("abort_done", {63'd0, bus.done_o}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("idle_after_reset", {63'd0, bus.busy_o}, 64'd0);
    exp_q = {31'h20, 31'h21, 31'h22};
    run(3'b100, 31'h20, 31'hFF, 8'd1, 32'd3, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
